// File: rtl/spi_regfile_pkg.sv
// ---------------------------------------------------------------------------
// spi_regfile_pkg : shared FSM state type and command-byte layout constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_regfile_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam int CMD_W      = 8;
   localparam int CMD_WR_BIT = 7;
endpackage

`default_nettype wire

// File: rtl/spi_regfile_if.sv
// ---------------------------------------------------------------------------
// spi_regfile_if : four-wire SPI bus bundle with master/slave views
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_regfile_if;
   logic spi_cs_n;
   logic spi_clk;
   logic spi_mosi;
   logic spi_miso;

   modport master (output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
   modport slave  (input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge : 2-flop synchronizer with rise/fall detect on the synced level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;
endmodule

`default_nettype wire

// File: rtl/spi_regfile.sv
// ---------------------------------------------------------------------------
// spi_regfile : SPI mode-0 slave register file; SPI_REGFILE_BURST_EN enables
// auto-increment bursts. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_regfile
   import spi_regfile_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   spi_regfile_if.slave                  spi,
   input  logic [REG_W-1:0]              status_i,
   output logic [(2**ADDR_W)*REG_W-1:0]  regs_o,
   output logic [(2**ADDR_W)-1:0]        wr_pulse_o
);
   localparam int         NUM_REGS = 2**ADDR_W;
   localparam logic [4:0] CMD_LAST = 5'(CMD_W - 1);
   localparam logic [4:0] WORD_LAST = 5'(REG_W - 1);

   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic unused_sync;

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .d_i(spi.spi_cs_n),
      .sync_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .d_i(spi.spi_clk),
      .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   assign unused_sync = cs_rise ^ sclk_lvl;

   state_e                            state_q, state_d;
   logic [4:0]                        cnt_q, cnt_d;
   logic [CMD_W-2:0]                  cmd_q, cmd_d, cmd_next;
   logic [REG_W-1:0]                  shift_q, shift_d, shift_in;
   logic [ADDR_W-1:0]                 addr_q, addr_d, rd_addr;
   logic                              write_q, write_d;
   logic [NUM_REGS-1:0][REG_W-1:0]    regs_q, regs_d;
   logic [NUM_REGS-1:0]               wr_pulse_q, wr_pulse_d;
   logic                              mosi_meta_q, mosi_meta_d, mosi_q, mosi_d;
   logic [1:0]                        settle_q, settle_d;
   logic                              armed_q, armed_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      write_d     = write_q;
      regs_d      = regs_q;
      wr_pulse_d  = '0;
      armed_d     = armed_q;
      mosi_meta_d = spi.spi_mosi;
      mosi_d      = mosi_meta_q;
      settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      cmd_next    = {cmd_q[CMD_W-3:0], mosi_q};
      shift_in    = (shift_q << 1) | REG_W'(mosi_q);
      rd_addr     = cmd_next[ADDR_W-1:0];

      // The synced chip select holds its reset value for two clocks, so only
      // trust a high level once it reflects the pin; a frame cut by reset is
      // then ignored until the master really deasserts chip select.
      if (settle_q[1] && cs_lvl) armed_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (cs_fall && armed_q) begin
               state_d = CMD;
               cnt_d   = '0;
            end
         end
         CMD: begin
            if (sclk_rise) begin
               cmd_d = cmd_next;
               if (cnt_q == CMD_LAST) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  write_d = cmd_q[CMD_WR_BIT-1];
                  addr_d  = rd_addr;
                  shift_d = (rd_addr == '0) ? status_i : regs_q[rd_addr];
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               if (write_q) shift_d = shift_in;
               if (cnt_q == WORD_LAST) begin
                  cnt_d = '0;
                  if (write_q) begin
                     regs_d[addr_q]     = shift_in;
                     wr_pulse_d[addr_q] = 1'b1;
                  end
`ifdef SPI_REGFILE_BURST_EN
                  addr_d = addr_q + ADDR_W'(1);
                  if (!write_q)
                     shift_d = (addr_d == '0) ? status_i : regs_q[addr_d];
`else
                  state_d = HOLD;
`endif
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end else if (sclk_fall && !write_q && cnt_q != '0) begin
               // The fall right after a load must keep the MSB on the line.
               shift_d = shift_q << 1;
            end
         end
         default: ;
      endcase

      if (cs_lvl) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         regs_q      <= '0;
         wr_pulse_q  <= '0;
         mosi_meta_q <= 1'b0;
         mosi_q      <= 1'b0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         regs_q      <= regs_d;
         wr_pulse_q  <= wr_pulse_d;
         mosi_meta_q <= mosi_meta_d;
         mosi_q      <= mosi_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
      end
   end

   assign regs_o       = regs_q;
   assign wr_pulse_o   = wr_pulse_q;
   assign spi.spi_miso = ~spi.spi_cs_n & (state_q == DATA) & ~write_q & shift_q[REG_W-1];
endmodule

`default_nettype wire
